// File: rtl/prco_decode_stage.sv
// Buffered decode stage: queues fetch words, decodes the head entry, and holds
// back RAW/WAW hazards against a register scoreboard before a registered issue.
package prco_decode_pkg;
    localparam int PRCO_OP_NOP  = 0;
    localparam int PRCO_OP_MOV  = 1;
    localparam int PRCO_OP_MOVI = 2;
endpackage

module prco_decode_stage
    import prco_decode_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int OP_W       = 5,
    parameter int REG_W      = 3,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter logic [2**OP_W-1:0] WE_MASK = (1 << PRCO_OP_MOVI) | (1 << PRCO_OP_MOV),
    parameter logic [2**OP_W-1:0] RD_MASK = (1 << PRCO_OP_MOV)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [INSTR_W-1:0]     i_instr,
    input  logic                   i_valid,
    output logic                   q_ready,
    input  logic                   i_flush,
    input  logic                   i_wb_valid,
    input  logic [REG_W-1:0]       i_wb_sel,
    output logic                   q_valid,
    input  logic                   i_ready,
    output logic [OP_W-1:0]        q_op,
    output logic [REG_W-1:0]       q_seld,
    output logic [REG_W-1:0]       q_sela,
    output logic [REG_W-1:0]       q_selb,
    output logic [DATA_W-1:0]      q_imm,
    output logic                   q_reg_we,
    output logic [(2**REG_W)-1:0]  q_busy
);
    localparam int NREG    = 2**REG_W;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int SELD_HI = INSTR_W - OP_W - 1;
    localparam int SELA_HI = SELD_HI - REG_W;
    localparam int SELB_HI = SELA_HI - REG_W;

    logic [INSTR_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               outValid_q, outValid_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [REG_W-1:0]   seld_q, seld_d, sela_q, sela_d, selb_q, selb_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic               regWe_q, regWe_d;
    logic [NREG-1:0]    busy_q, busy_d;

    logic [INSTR_W-1:0] headInstr;
    logic [OP_W-1:0]    headOp;
    logic [REG_W-1:0]   headSeld, headSela, headSelb;
    logic [DATA_W-1:0]  headImm;
    logic               headWe, headRd;
    logic               notEmpty, full, readyInt, push, hazard, issue;

    assign headInstr = fifoMem_q[rdPtr_q];
    assign headOp    = headInstr[INSTR_W-1 -: OP_W];
    assign headSeld  = headInstr[SELD_HI -: REG_W];
    assign headSela  = headInstr[SELA_HI -: REG_W];
    assign headSelb  = headInstr[SELB_HI -: REG_W];
    assign headImm   = {{(DATA_W-8){1'b0}}, headInstr[7:0]};
    assign headWe    = WE_MASK[headOp];
    assign headRd    = RD_MASK[headOp];

    assign notEmpty = (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign readyInt = !full && !i_rst;
    assign push     = i_valid && readyInt;
    // Scoreboard check sees only the registered busy bits, so a writeback
    // releases a stalled head one cycle after it arrives.
    assign hazard   = notEmpty && ((headRd && busy_q[headSela]) ||
                                   (headWe && busy_q[headSeld]));
    assign issue    = notEmpty && !hazard && (!outValid_q || i_ready);

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        outValid_d = outValid_q;
        op_d       = op_q;
        seld_d     = seld_q;
        sela_d     = sela_q;
        selb_d     = selb_q;
        imm_d      = imm_q;
        regWe_d    = regWe_q;
        busy_d     = busy_q;

        if (i_wb_valid) begin
            busy_d[i_wb_sel] = 1'b0;
        end

        if (i_flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            outValid_d = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            // Issue's busy set comes after the writeback clear so it wins.
            if (issue) begin
                rdPtr_d    = rdPtr_q + PW'(1);
                outValid_d = 1'b1;
                op_d       = headOp;
                seld_d     = headSeld;
                sela_d     = headSela;
                selb_d     = headSelb;
                imm_d      = headImm;
                regWe_d    = headWe;
                if (headWe) begin
                    busy_d[headSeld] = 1'b1;
                end
            end else if (i_ready) begin
                outValid_d = 1'b0;
            end
            count_d = count_q + CW'(push) - CW'(issue);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            op_q       <= '0;
            seld_q     <= '0;
            sela_q     <= '0;
            selb_q     <= '0;
            imm_q      <= '0;
            regWe_q    <= 1'b0;
            busy_q     <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            op_q       <= op_d;
            seld_q     <= seld_d;
            sela_q     <= sela_d;
            selb_q     <= selb_d;
            imm_q      <= imm_d;
            regWe_q    <= regWe_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            fifoMem_q[wrPtr_q] <= i_instr;
        end
    end

    assign q_ready  = readyInt;
    assign q_valid  = outValid_q;
    assign q_op     = op_q;
    assign q_seld   = seld_q;
    assign q_sela   = sela_q;
    assign q_selb   = selb_q;
    assign q_imm    = imm_q;
    assign q_reg_we = regWe_q;
    assign q_busy   = busy_q;
endmodule

// File: tb/tb_prco_decode_stage.sv
// Bench for prco_decode_stage: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_prco_decode_stage;
    import prco_decode_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_instr;
    logic        i_valid;
    logic        q_ready;
    logic        i_flush;
    logic        i_wb_valid;
    logic [2:0]  i_wb_sel;
    logic        q_valid;
    logic        i_ready;
    logic [4:0]  q_op;
    logic [2:0]  q_seld, q_sela, q_selb;
    logic [15:0] q_imm;
    logic        q_reg_we;
    logic [7:0]  q_busy;

    int checkCount = 0;
    int errorCount = 0;
    logic checkEnable = 1'b0;

    prco_decode_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid),
        .q_ready(q_ready), .i_flush(i_flush), .i_wb_valid(i_wb_valid),
        .i_wb_sel(i_wb_sel), .q_valid(q_valid), .i_ready(i_ready), .q_op(q_op),
        .q_seld(q_seld), .q_sela(q_sela), .q_selb(q_selb), .q_imm(q_imm),
        .q_reg_we(q_reg_we), .q_busy(q_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference state: pending words in arrival order, the word on the output,
    // and which registers have an outstanding write.
    logic [15:0] mq[$];
    logic        mValid = 1'b0;
    logic [15:0] mOut = '0;
    logic [7:0]  mBusy = '0;
    logic [7:0]  nextBusy;
    logic [15:0] headWord;
    logic        canPush, canIssue;

    function automatic logic [15:0] enc(input int op, input logic [2:0] d, input logic [7:0] low);
        logic [4:0] o;
        o = op[4:0];
        return {o, d, low};
    endfunction

    function automatic logic writesDest(input logic [15:0] w);
        return (w[15:11] == PRCO_OP_MOV[4:0]) || (w[15:11] == PRCO_OP_MOVI[4:0]);
    endfunction

    function automatic logic readsSrcA(input logic [15:0] w);
        return w[15:11] == PRCO_OP_MOV[4:0];
    endfunction

    function automatic logic blocked(input logic [15:0] w, input logic [7:0] b);
        return (readsSrcA(w) && b[w[7:5]]) || (writesDest(w) && b[w[10:8]]);
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            mq.delete();
            mValid = 1'b0;
            mOut   = '0;
            mBusy  = '0;
        end else begin
            canPush  = i_valid && (mq.size() < 4);
            canIssue = 1'b0;
            headWord = '0;
            if (mq.size() > 0) begin
                headWord = mq[0];
                canIssue = !blocked(headWord, mBusy) && (!mValid || i_ready);
            end
            nextBusy = mBusy;
            if (i_wb_valid) nextBusy[i_wb_sel] = 1'b0;
            if (i_flush) begin
                mq.delete();
                mValid = 1'b0;
            end else begin
                if (canIssue) begin
                    void'(mq.pop_front());
                    mOut   = headWord;
                    mValid = 1'b1;
                    if (writesDest(headWord)) nextBusy[headWord[10:8]] = 1'b1;
                end else if (i_ready) begin
                    mValid = 1'b0;
                end
                if (canPush) mq.push_back(i_instr);
            end
            mBusy = nextBusy;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle after reset is applied, compare all outputs to the model.
    always @(negedge i_clk) begin
        if (checkEnable) begin
            checkOutput("cyc_q_valid", q_valid, mValid);
            checkOutput("cyc_q_ready", q_ready, !i_rst && (mq.size() < 4));
            checkOutput("cyc_q_busy", q_busy, mBusy);
            checkOutput("cyc_q_op", q_op, mOut[15:11]);
            checkOutput("cyc_q_seld", q_seld, mOut[10:8]);
            checkOutput("cyc_q_sela", q_sela, mOut[7:5]);
            checkOutput("cyc_q_selb", q_selb, mOut[4:2]);
            checkOutput("cyc_q_imm", q_imm, {8'h00, mOut[7:0]});
            checkOutput("cyc_q_reg_we", q_reg_we, writesDest(mOut));
        end
    end

    task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic fl,
                                 input logic wbv, input logic [2:0] wbs);
        i_valid    = v;
        i_instr    = instr;
        i_flush    = fl;
        i_wb_valid = wbv;
        i_wb_sel   = wbs;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_ready = 1'b0; i_valid = 1'b0; i_instr = '0;
        i_flush = 1'b0; i_wb_valid = 1'b0; i_wb_sel = '0;

        // Reset held for two cycles
        idle();
        checkEnable = 1'b1;
        idle();
        i_rst = 1'b0;
        #1;
        checkOutput("rst_valid", q_valid, 0);
        checkOutput("rst_op", q_op, 0);
        checkOutput("rst_we", q_reg_we, 0);
        checkOutput("rst_busy", q_busy, 8'h00);
        checkOutput("rst_ready", q_ready, 1);

        // Basic issue
        i_ready = 1'b1;
        applyStimulus(1'b1, enc(PRCO_OP_MOVI, 3'd0, 8'hAB), 1'b0, 1'b0, 3'd0);
        idle();
        checkOutput("basic_valid", q_valid, 1);
        checkOutput("basic_op", q_op, PRCO_OP_MOVI);
        checkOutput("basic_seld", q_seld, 0);
        checkOutput("basic_imm", q_imm, 16'h00AB);
        checkOutput("basic_we", q_reg_we, 1);
        checkOutput("basic_busy", q_busy, 8'h01);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h00), 1'b0, 1'b0, 3'd0);
        idle();
        checkOutput("nop_op", q_op, PRCO_OP_NOP);
        checkOutput("nop_we", q_reg_we, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 3'd0);
        idle();

        // RAW stall and release
        applyStimulus(1'b1, enc(PRCO_OP_MOVI, 3'd1, 8'hCD), 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, enc(PRCO_OP_MOV, 3'd2, {3'd1, 3'd0, 2'b00}), 1'b0, 1'b0, 3'd0);
        idle();
        idle();
        checkOutput("raw_held_valid", q_valid, 0);
        checkOutput("raw_held_busy", q_busy, 8'h02);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 3'd1);
        checkOutput("raw_wb_valid", q_valid, 0);
        checkOutput("raw_wb_busy", q_busy, 8'h00);
        idle();
        checkOutput("raw_issue_valid", q_valid, 1);
        checkOutput("raw_issue_op", q_op, PRCO_OP_MOV);
        checkOutput("raw_issue_seld", q_seld, 2);
        checkOutput("raw_issue_sela", q_sela, 1);
        checkOutput("raw_issue_we", q_reg_we, 1);
        checkOutput("raw_issue_busy", q_busy, 8'h04);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 3'd2);
        idle();

        // Backpressure: five fit, the sixth waits for space
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'(k)), 1'b0, 1'b0, 3'd0);
        end
        checkOutput("bp_full_ready", q_ready, 0);
        checkOutput("bp_full_imm", q_imm, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'd6), 1'b0, 1'b0, 3'd0);
            checkOutput("bp_hold_imm", q_imm, 16'h0001);
            checkOutput("bp_hold_valid", q_valid, 1);
        end
        i_ready = 1'b1;
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'd6), 1'b0, 1'b0, 3'd0);
        checkOutput("bp_drain_imm2", q_imm, 16'h0002);
        checkOutput("bp_space_ready", q_ready, 1);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'd6), 1'b0, 1'b0, 3'd0);
        checkOutput("bp_drain_imm3", q_imm, 16'h0003);
        for (int k = 4; k <= 6; k++) begin
            idle();
            checkOutput("bp_drain_imm", q_imm, 32'(k));
            checkOutput("bp_drain_valid", q_valid, 1);
        end
        idle();
        checkOutput("bp_empty_valid", q_valid, 0);

        // Flush with FIFO full and busy[3] set
        applyStimulus(1'b1, enc(PRCO_OP_MOVI, 3'd3, 8'h33), 1'b0, 1'b0, 3'd0);
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'(8'h10 + k)), 1'b0, 1'b0, 3'd0);
        end
        checkOutput("fl_full_ready", q_ready, 0);
        checkOutput("fl_full_busy", q_busy, 8'h08);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h20), 1'b1, 1'b0, 3'd0);
        checkOutput("fl_valid", q_valid, 0);
        checkOutput("fl_ready", q_ready, 1);
        checkOutput("fl_busy", q_busy, 8'h08);
        i_ready = 1'b1;
        idle();
        checkOutput("fl_after_valid", q_valid, 0);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h40), 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h41), 1'b1, 1'b1, 3'd3);
        checkOutput("fl2_valid", q_valid, 0);
        checkOutput("fl2_busy", q_busy, 8'h00);
        idle();
        checkOutput("fl2_after_valid", q_valid, 0);

        // WAW hazard, then issue set coinciding with a writeback clear
        applyStimulus(1'b1, enc(PRCO_OP_MOVI, 3'd4, 8'h01), 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, enc(PRCO_OP_MOVI, 3'd4, 8'h02), 1'b0, 1'b0, 3'd0);
        idle();
        checkOutput("waw_held_valid", q_valid, 0);
        checkOutput("waw_held_busy", q_busy, 8'h10);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4);
        checkOutput("waw_clr_busy", q_busy, 8'h00);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4);
        checkOutput("setclr_busy", q_busy, 8'h10);
        checkOutput("setclr_valid", q_valid, 1);
        checkOutput("setclr_imm", q_imm, 16'h0002);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4);
        idle();

        // Reset mid-stream overrides flush and writeback
        i_ready = 1'b0;
        applyStimulus(1'b1, enc(PRCO_OP_MOVI, 3'd5, 8'h55), 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h56), 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h57), 1'b0, 1'b0, 3'd0);
        checkOutput("mid_busy", q_busy, 8'h20);
        i_rst = 1'b1;
        applyStimulus(1'b1, enc(PRCO_OP_NOP, 3'd0, 8'h58), 1'b1, 1'b1, 3'd5);
        checkOutput("mid_rst_valid", q_valid, 0);
        checkOutput("mid_rst_busy", q_busy, 8'h00);
        checkOutput("mid_rst_imm", q_imm, 16'h0000);
        checkOutput("mid_rst_ready", q_ready, 0);
        i_rst = 1'b0;
        i_ready = 1'b1;
        idle();
        checkOutput("mid_after_valid", q_valid, 0);
        checkOutput("mid_after_ready", q_ready, 1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
